// File: rtl/nn_layer_sequencer_pkg.sv
// Shared definitions for the char_reg MLP layer sequencer: network
// dimensions, bus widths, FSM state encoding and small decode helpers.
package nn_layer_sequencer_pkg;

  // Network shape (8x8 pixels -> 16 hidden -> 10 classes)
  localparam int N_IN  = 64;
  localparam int N_HID = 16;
  localparam int N_OUT = 10;

  // Datapath widths. The weight ROM must hold N_HID*N_IN + N_OUT*N_HID rows;
  // layer-2 rows start directly after the layer-1 rows (base N_HID*N_IN).
  localparam int ACC_W = 24;
  localparam int WA_W  = 11;
  localparam int IA_W  = 6;
  localparam int HA_W  = 4;
  localparam int CLS_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WB    = 3'd3,
    ST_FIN   = 3'd4
  } seq_state_t;

  typedef enum logic {
    LAYER_HID = 1'b0,
    LAYER_OUT = 1'b1
  } layer_t;

  // True for the states in which a run is in progress (busy window)
  function automatic logic in_run(input seq_state_t st);
    logic r;
    case (st)
      ST_ISSUE, ST_DRAIN, ST_WB: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Bus between the layer sequencer and the char_reg datapath / top-level
// control: run handshake, MAC operand addressing, strobes and result.
interface nn_layer_sequencer_if;
  import nn_layer_sequencer_pkg::*;

  logic                    start;
  logic signed [ACC_W-1:0] acc;
  logic                    in_sel;
  logic [IA_W-1:0]         in_addr;
  logic [WA_W-1:0]         w_addr;
  logic                    mac_clr;
  logic                    mac_en;
  logic                    hid_we;
  logic [HA_W-1:0]         hid_waddr;
  logic                    busy;
  logic                    done;
  logic [CLS_W-1:0]        result;

  // Sequencer side
  modport master (
    input  start, acc,
    output in_sel, in_addr, w_addr, mac_clr, mac_en, hid_we, hid_waddr,
           busy, done, result
  );

  // Datapath / control side
  modport slave (
    output start, acc,
    input  in_sel, in_addr, w_addr, mac_clr, mac_en, hid_we, hid_waddr,
           busy, done, result
  );

endinterface

// File: rtl/nn_layer_sequencer_score_argmax.sv
// Running signed argmax over the output-layer scores. A candidate replaces
// the current best only on a strictly greater score, so ties keep the
// earlier (lower) index. best_idx already reflects the candidate presented
// this cycle, letting the caller latch the final winner on the last WB.
module nn_layer_sequencer_score_argmax
  import nn_layer_sequencer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [ACC_W-1:0] score,
  input  logic [CLS_W-1:0]        idx_in,
  output logic [CLS_W-1:0]        best_idx
);

  localparam logic signed [ACC_W-1:0] SCORE_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] best_score_r;
  logic [CLS_W-1:0]        best_idx_r;
  logic                    take_s;

  // Candidate wins only when enabled and strictly above the best so far
  always_comb begin
    take_s = 1'b0;
    if (en && (score > best_score_r)) begin
      take_s = 1'b1;
    end else begin
      take_s = 1'b0;
    end
  end

  // Best score/index registers; cleared to the most-negative score per run
  always_ff @(posedge clk) begin
    if (rst) begin
      best_score_r <= SCORE_MIN;
      best_idx_r   <= CLS_W'(0);
    end else if (clr) begin
      best_score_r <= SCORE_MIN;
      best_idx_r   <= CLS_W'(0);
    end else if (take_s) begin
      best_score_r <= score;
      best_idx_r   <= idx_in;
    end else begin
      best_score_r <= best_score_r;
      best_idx_r   <= best_idx_r;
    end
  end

  assign best_idx = take_s ? idx_in : best_idx_r;

endmodule

// File: rtl/nn_layer_sequencer.sv
// Control FSM for the char_reg MLP: walks the MAC over pixels->hidden and
// hidden->output, issuing one operand address pair per cycle, then reports
// the argmax class. Each neuron takes fan-in issue cycles, one DRAIN cycle
// (last operand still accumulating) and one WB cycle (acc final).
module nn_layer_sequencer
  import nn_layer_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  nn_layer_sequencer_if.master bus
);

  localparam logic [IA_W-1:0] I_LAST_HID = IA_W'(N_IN - 1);
  localparam logic [IA_W-1:0] I_LAST_OUT = IA_W'(N_HID - 1);
  localparam logic [HA_W-1:0] N_LAST_HID = HA_W'(N_HID - 1);
  localparam logic [HA_W-1:0] N_LAST_OUT = HA_W'(N_OUT - 1);

  seq_state_t       state_r,  state_nx;
  logic [IA_W-1:0]  i_r,      i_nx;
  logic [HA_W-1:0]  neuron_r, neuron_nx;
  layer_t           layer_r,  layer_nx;
  logic [WA_W-1:0]  w_addr_r, w_addr_nx;
  logic             mac_clr_r, mac_clr_nx;
  logic             hid_we_r,  hid_we_nx;
  logic             busy_r,    busy_nx;
  logic             done_r,    done_nx;
  logic [CLS_W-1:0] result_r,  result_nx;
  logic             mac_en_r;

  logic             i_last_s;
  logic             n_last_s;
  logic             argmax_clr_s;
  logic             argmax_en_s;
  logic [CLS_W-1:0] best_idx_s;

  assign i_last_s     = (layer_r == LAYER_HID) ? (i_r == I_LAST_HID) : (i_r == I_LAST_OUT);
  assign n_last_s     = (layer_r == LAYER_HID) ? (neuron_r == N_LAST_HID) : (neuron_r == N_LAST_OUT);
  assign argmax_clr_s = (state_r == ST_IDLE) && bus.start;
  assign argmax_en_s  = (state_r == ST_WB) && (layer_r == LAYER_OUT);

  nn_layer_sequencer_score_argmax u_argmax (
    .clk      (clk),
    .rst      (rst),
    .clr      (argmax_clr_s),
    .en       (argmax_en_s),
    .score    (bus.acc),
    .idx_in   (neuron_r),
    .best_idx (best_idx_s)
  );

  // Next-state, counter and registered-output decode
  always_comb begin
    state_nx  = state_r;
    i_nx      = i_r;
    neuron_nx = neuron_r;
    layer_nx  = layer_r;
    w_addr_nx = w_addr_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx  = ST_ISSUE;
          i_nx      = IA_W'(0);
          neuron_nx = HA_W'(0);
          layer_nx  = LAYER_HID;
          w_addr_nx = WA_W'(0);
        end else begin
          state_nx  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // weight rows are consumed strictly in order across both layers
        w_addr_nx = w_addr_r + WA_W'(1);
        if (i_last_s) begin
          state_nx = ST_DRAIN;
          i_nx     = IA_W'(0);
        end else begin
          state_nx = ST_ISSUE;
          i_nx     = i_r + IA_W'(1);
        end
      end
      ST_DRAIN: begin
        state_nx = ST_WB;
      end
      ST_WB: begin
        if (!n_last_s) begin
          state_nx  = ST_ISSUE;
          neuron_nx = neuron_r + HA_W'(1);
        end else if (layer_r == LAYER_HID) begin
          state_nx  = ST_ISSUE;
          neuron_nx = HA_W'(0);
          layer_nx  = LAYER_OUT;
        end else begin
          state_nx  = ST_FIN;
        end
      end
      ST_FIN: begin
        // return to IDLE with counters cleared so idle outputs read zero
        state_nx  = ST_IDLE;
        i_nx      = IA_W'(0);
        neuron_nx = HA_W'(0);
        layer_nx  = LAYER_HID;
        w_addr_nx = WA_W'(0);
      end
      default: begin
        state_nx  = ST_IDLE;
        i_nx      = IA_W'(0);
        neuron_nx = HA_W'(0);
        layer_nx  = LAYER_HID;
        w_addr_nx = WA_W'(0);
      end
    endcase

    busy_nx    = in_run(state_nx);
    done_nx    = (state_nx == ST_FIN);
    mac_clr_nx = (state_nx == ST_ISSUE) && (i_nx == IA_W'(0));
    hid_we_nx  = (state_nx == ST_WB) && (layer_nx == LAYER_HID);
    if (state_nx == ST_FIN) begin
      result_nx = best_idx_s;
    end else begin
      result_nx = result_r;
    end
  end

  // State, counters and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      i_r       <= IA_W'(0);
      neuron_r  <= HA_W'(0);
      layer_r   <= LAYER_HID;
      w_addr_r  <= WA_W'(0);
      mac_clr_r <= 1'b0;
      hid_we_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= CLS_W'(0);
      mac_en_r  <= 1'b0;
    end else begin
      state_r   <= state_nx;
      i_r       <= i_nx;
      neuron_r  <= neuron_nx;
      layer_r   <= layer_nx;
      w_addr_r  <= w_addr_nx;
      mac_clr_r <= mac_clr_nx;
      hid_we_r  <= hid_we_nx;
      busy_r    <= busy_nx;
      done_r    <= done_nx;
      result_r  <= result_nx;
      // operand data arrives one cycle after its address is issued
      mac_en_r  <= (state_r == ST_ISSUE);
    end
  end

  assign bus.in_sel    = (layer_r == LAYER_OUT);
  assign bus.in_addr   = i_r;
  assign bus.w_addr    = w_addr_r;
  assign bus.mac_clr   = mac_clr_r;
  assign bus.mac_en    = mac_en_r;
  assign bus.hid_we    = hid_we_r;
  assign bus.hid_waddr = neuron_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.result    = result_r;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer: 1-cycle pixel RAM / weight ROM, behavioural
// MAC and hidden buffer around the DUT; expected classes, hidden values and
// strobe/address sequences come from a loop-level model of the network.
module tb_nn_layer_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  nn_layer_sequencer_if bus_if();

  nn_layer_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // ---------------- datapath model ----------------
  int pix [0:63];
  int rom [0:2047];
  int hid [0:15];
  int force_score [0:9];
  int opnd_q = 0;
  int w_q = 0;
  logic signed [23:0] acc_r = 24'sd0;

  assign bus_if.acc = acc_r;

  function automatic int act(input logic signed [23:0] a);
    int v;
    v = int'(a);
    if (v < 0) return 0;
    else if (v > 127) return 127;
    else return v;
  endfunction

  function automatic int wrap24(input longint s);
    logic signed [23:0] t;
    t = s[23:0];
    return int'(t);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    opnd_q <= bus_if.in_sel ? hid[bus_if.in_addr[3:0]] : pix[bus_if.in_addr];
    w_q    <= rom[bus_if.w_addr];
    if (bus_if.mac_clr) acc_r <= 24'sd0;
    else if (bus_if.mac_en) acc_r <= acc_r + 24'(opnd_q * w_q);
    if (bus_if.hid_we) hid[bus_if.hid_waddr] <= act(acc_r);
  end

  // ---------------- strobe monitor ----------------
  logic mon_clr = 1'b1;
  int n_issue = 0, n_clr = 0, n_hwe = 0, n_done = 0;
  int addr_err = 0, clr_err = 0, hwe_err = 0, stray = 0, done_busy = 0;
  logic [10:0] p_w_addr = 11'd0;
  logic        p_in_sel = 1'b0;
  logic [5:0]  p_in_addr = 6'd0;

  function automatic logic [5:0] exp_in_addr(input int k);
    if (k < 1024) return 6'(k % 64);
    else return 6'((k - 1024) % 16);
  endfunction

  always @(negedge clk) begin
    p_w_addr  <= bus_if.w_addr;
    p_in_sel  <= bus_if.in_sel;
    p_in_addr <= bus_if.in_addr;
    if (mon_clr) begin
      n_issue <= 0; n_clr <= 0; n_hwe <= 0; n_done <= 0;
      addr_err <= 0; clr_err <= 0; hwe_err <= 0; stray <= 0; done_busy <= 0;
    end else begin
      if (bus_if.mac_en) begin
        n_issue <= n_issue + 1;
        if (p_w_addr !== 11'(n_issue) || p_in_sel !== (n_issue >= 1024) ||
            p_in_addr !== exp_in_addr(n_issue))
          addr_err <= addr_err + 1;
      end
      if (bus_if.mac_clr) begin
        n_clr <= n_clr + 1;
        if (bus_if.in_addr !== 6'd0) clr_err <= clr_err + 1;
      end
      if (bus_if.hid_we) begin
        n_hwe <= n_hwe + 1;
        if (bus_if.hid_waddr !== 4'(n_hwe) || bus_if.in_sel !== 1'b0) hwe_err <= hwe_err + 1;
      end
      if ((bus_if.mac_en || bus_if.mac_clr || bus_if.hid_we) && !bus_if.busy) stray <= stray + 1;
      if (bus_if.done) begin
        n_done <= n_done + 1;
        if (bus_if.busy) done_busy <= done_busy + 1;
      end
    end
  end

  // ---------------- reference model ----------------
  int exp_hid [0:15];
  int exp_score [0:9];
  int exp_cls;

  task automatic model_run();
    longint s;
    for (int j = 0; j < 16; j++) begin
      s = 0;
      for (int p = 0; p < 64; p++) s += longint'(pix[p]) * longint'(rom[j*64 + p]);
      exp_hid[j] = act(s[23:0]);
    end
    for (int k = 0; k < 10; k++) begin
      s = 0;
      for (int j = 0; j < 16; j++) s += longint'(exp_hid[j]) * longint'(rom[1024 + k*16 + j]);
      exp_score[k] = wrap24(s);
    end
    exp_cls = 0;
    for (int k = 1; k < 10; k++) if (exp_score[k] > exp_score[exp_cls]) exp_cls = k;
  endtask

  // Pixels all 1, each hidden neuron sees only pixel 0 with weight 1, each
  // output k sees only hidden 0 with weight force_score[k]: score k = force_score[k].
  task automatic load_forced();
    for (int a = 0; a < 2048; a++) rom[a] = 0;
    for (int p = 0; p < 64; p++) pix[p] = 1;
    for (int j = 0; j < 16; j++) rom[j*64] = 1;
    for (int k = 0; k < 10; k++) rom[1024 + k*16] = force_score[k];
  endtask

  task automatic load_random();
    for (int a = 0; a < 2048; a++) rom[a] = 0;
    for (int p = 0; p < 64; p++) pix[p] = int'($urandom_range(255, 0)) - 128;
    for (int a = 0; a < 1184; a++) rom[a] = int'($urandom_range(255, 0)) - 128;
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic wait_done(output int done_cyc);
    int t0;
    t0 = cyc;
    while (bus_if.done !== 1'b1 && (cyc - t0) < 1400) tick();
    done_cyc = cyc;
  endtask

  task automatic run_once(input string tag, input int exp_res);
    int start_cyc, done_cyc;
    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
    bus_if.start = 1'b1;
    start_cyc = cyc;
    tick();
    bus_if.start = 1'b0;
    chk({tag, "_busy_rise"}, int'(bus_if.busy), 1);
    wait_done(done_cyc);
    chk({tag, "_latency"}, done_cyc - start_cyc, 1237);
    chk({tag, "_result"}, int'(bus_if.result), exp_res);
    chk({tag, "_busy_at_done"}, int'(bus_if.busy), 0);
    tick();
    chk({tag, "_n_issue"}, n_issue, 1184);
    chk({tag, "_n_mac_clr"}, n_clr, 26);
    chk({tag, "_n_hid_we"}, n_hwe, 16);
    chk({tag, "_addr_trace"}, addr_err, 0);
    chk({tag, "_clr_trace"}, clr_err, 0);
    chk({tag, "_hwe_trace"}, hwe_err, 0);
    chk({tag, "_stray"}, stray, 0);
    chk({tag, "_n_done"}, n_done, 1);
    chk({tag, "_done_busy"}, done_busy, 0);
    chk({tag, "_result_held"}, int'(bus_if.result), exp_res);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, d2;
    rst = 1'b1;
    bus_if.start = 1'b0;
    for (int a = 0; a < 16; a++) hid[a] = 0;
    repeat (3) tick();

    // reset state
    chk("rst_busy", int'(bus_if.busy), 0);
    chk("rst_done", int'(bus_if.done), 0);
    chk("rst_mac_en", int'(bus_if.mac_en), 0);
    chk("rst_mac_clr", int'(bus_if.mac_clr), 0);
    chk("rst_hid_we", int'(bus_if.hid_we), 0);
    chk("rst_result", int'(bus_if.result), 0);
    chk("rst_w_addr", int'(bus_if.w_addr), 0);
    chk("rst_in_sel", int'(bus_if.in_sel), 0);
    rst = 1'b0;
    tick();

    // output 7 wins clearly
    for (int k = 0; k < 10; k++) force_score[k] = int'($urandom_range(100, 0)) - 50;
    force_score[7] = 100;
    load_forced();
    run_once("win7", 7);

    // tie between 3 and 8 keeps lower index
    for (int k = 0; k < 10; k++) force_score[k] = int'($urandom_range(199, 0)) - 100;
    force_score[3] = 200;
    force_score[8] = 200;
    load_forced();
    run_once("tie3", 3);

    // all-negative scores, signed compare
    for (int k = 0; k < 10; k++) force_score[k] = -6 - int'($urandom_range(1000, 0));
    force_score[9] = -5;
    load_forced();
    run_once("neg9", 9);

    // reset mid-run
    bus_if.start = 1'b1; tick(); bus_if.start = 1'b0;
    repeat (500) tick();
    rst = 1'b1;
    tick();
    chk("midrst_busy", int'(bus_if.busy), 0);
    chk("midrst_mac_en", int'(bus_if.mac_en), 0);
    chk("midrst_result", int'(bus_if.result), 0);
    chk("midrst_done", int'(bus_if.done), 0);
    tick();
    rst = 1'b0;
    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
    repeat (1300) tick();
    chk("midrst_no_done", n_done, 0);
    chk("midrst_idle_busy", int'(bus_if.busy), 0);
    chk("midrst_no_stray", stray, 0);

    // randomized network data against the model
    for (int r = 0; r < 2; r++) begin
      load_random();
      model_run();
      run_once($sformatf("rand%0d", r), exp_cls);
      for (int j = 0; j < 16; j++) chk($sformatf("rand%0d_hid%0d", r, j), hid[j], exp_hid[j]);
    end

    // start held high: ignored while busy, restarts in IDLE cycle after done
    for (int k = 0; k < 10; k++) force_score[k] = int'($urandom_range(100, 0)) - 50;
    force_score[2] = 150;
    load_forced();
    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
    bus_if.start = 1'b1;
    d2 = cyc;
    tick();
    wait_done(d1);
    chk("hold_latency1", d1 - d2, 1237);
    chk("hold_result1", int'(bus_if.result), 2);
    tick();
    chk("hold_idle_busy", int'(bus_if.busy), 0);
    tick();
    chk("hold_restart_busy", int'(bus_if.busy), 1);
    chk("hold_single_done", n_done, 1);
    bus_if.start = 1'b0;
    wait_done(d2);
    chk("hold_latency2", d2 - d1, 1238);
    chk("hold_result2", int'(bus_if.result), 2);
    tick();
    chk("hold_n_done", n_done, 2);
    chk("hold_stray", stray, 0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
